// File: rtl/uart_filter_pkg.sv
// Shared helpers for the multi-channel UART RX deglitch filter.
// Optional glitch counting is enabled by UART_RX_FILTER_GLITCH_CNT_EN.
package uart_filter_pkg;

  localparam bit IDLE_LVL = 1'b1;

  function automatic int cmax(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  function automatic bit params_ok(
    input int sync,
    input int cnt_w,
    input int hi,
    input int lo
  );
    return (sync >= 2) && (lo >= 0) &&
           (lo < hi) && (hi <= cmax(cnt_w));
  endfunction

  function automatic int rail(
    input bit lvl,
    input int cnt_w
  );
    return lvl ? cmax(cnt_w) : 0;
  endfunction

endpackage

// File: rtl/uart_rx_filter_multi_if.sv
// Pin-side bundle between the line drivers and the RX filter.
// Glitch ports exist only with UART_RX_FILTER_GLITCH_CNT_EN.
interface uart_rx_filter_multi_if #(
  parameter int NCH = 1
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  , parameter int GCNT_W = 8
`endif
);

  logic           samp_clk;
  logic [NCH-1:0] in;
  logic [NCH-1:0] out;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;

`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  logic                  glitch_clr;
  logic [NCH*GCNT_W-1:0] glitch_cnt;

  modport master (
    output samp_clk, in, glitch_clr,
    input  out, rise, fall, glitch_cnt
  );

  modport slave (
    input  samp_clk, in, glitch_clr,
    output out, rise, fall, glitch_cnt
  );
`else
  modport master (
    output samp_clk, in,
    input  out, rise, fall
  );

  modport slave (
    input  samp_clk, in,
    output out, rise, fall
  );
`endif

endinterface

// File: rtl/uart_rx_filter_chan.sv
// One filter lane: synchroniser, hysteresis counter, level and strobes.
// Glitch counter present only with UART_RX_FILTER_GLITCH_CNT_EN.
module uart_rx_filter_chan
  import uart_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 2,
  parameter int THRESH_HI   = 3,
  parameter int THRESH_LO   = 0,
  parameter bit RESET_VAL   = IDLE_LVL
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  , parameter int GCNT_W    = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic samp_clk,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  , input  logic              glitch_clr
  , output logic [GCNT_W-1:0] glitch_cnt
`endif
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CMAX    = cnt_t'(cmax(CNT_W));
  localparam cnt_t HI      = cnt_t'(THRESH_HI);
  localparam cnt_t LO      = cnt_t'(THRESH_LO);
  localparam cnt_t CNT_RST = cnt_t'(rail(RESET_VAL, CNT_W));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_sync;
  logic                   out_d;
  cnt_t                   cnt_q;
  cnt_t                   cnt_d;

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      in_sync && (cnt_q != CMAX):
        cnt_d = cnt_q + 1'b1;
      !in_sync && (cnt_q != '0):
        cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  // Between the thresholds the level holds: that gap is the hysteresis.
  always_comb begin
    out_d = dout;
    unique case (1'b1)
      cnt_q >= HI: out_d = 1'b1;
      cnt_q <= LO: out_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q  <= CNT_RST;
      dout   <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= samp_clk & out_d & ~dout;
      fall <= samp_clk & ~out_d & dout;
      if (samp_clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        cnt_q  <= cnt_d;
        dout   <= out_d;
      end
    end
  end

`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  logic exc_q;
  logic exc_d;
  logic gevt;

  // An excursion that falls back to its rail without flipping the level.
  always_comb begin
    exc_d = exc_q;
    gevt  = 1'b0;
    if (out_d != dout) begin
      exc_d = 1'b0;
    end else if (dout ? (cnt_q < HI) : (cnt_q > LO)) begin
      exc_d = 1'b1;
    end else if (exc_q) begin
      exc_d = 1'b0;
      gevt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q      <= 1'b0;
      glitch_cnt <= '0;
    end else if (samp_clk) begin
      exc_q <= exc_d;
      if (glitch_clr)
        glitch_cnt <= '0;
      else if (gevt && (glitch_cnt != '1))
        glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_filter_multi.sv
// NCH independent deglitch lanes sharing one oversampling strobe.
// Define UART_RX_FILTER_GLITCH_CNT_EN for per-lane glitch counters.
module uart_rx_filter_multi
  import uart_filter_pkg::*;
#(
  parameter int NCH         = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 2,
  parameter int THRESH_HI   = 3,
  parameter int THRESH_LO   = 0,
  parameter bit RESET_VAL   = IDLE_LVL,
  parameter int GCNT_W      = 8
) (
  input logic                   clk,
  input logic                   rst,
  uart_rx_filter_multi_if.slave bus
);

  if (!params_ok(SYNC_STAGES, CNT_W, THRESH_HI, THRESH_LO)
      || (GCNT_W < 1)) begin : g_bad_params
    $error("uart_rx_filter_multi: illegal parameters");
  end

  logic [NCH-1:0] out_v;
  logic [NCH-1:0] rise_v;
  logic [NCH-1:0] fall_v;
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  logic [NCH*GCNT_W-1:0] gcnt_v;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    uart_rx_filter_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .THRESH_HI   (THRESH_HI),
      .THRESH_LO   (THRESH_LO),
      .RESET_VAL   (RESET_VAL)
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
      , .GCNT_W    (GCNT_W)
`endif
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .samp_clk   (bus.samp_clk),
      .din        (bus.in[i]),
      .dout       (out_v[i]),
      .rise       (rise_v[i]),
      .fall       (fall_v[i])
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
      , .glitch_clr (bus.glitch_clr)
      , .glitch_cnt (gcnt_v[i*GCNT_W +: GCNT_W])
`endif
    );
  end

  assign bus.out  = out_v;
  assign bus.rise = rise_v;
  assign bus.fall = fall_v;
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  assign bus.glitch_cnt = gcnt_v;
`endif

endmodule

// File: tb/tb_uart_rx_filter_multi.sv
// Bench: two filter instances (default and wide-counter) against a lane model.
// Glitch checks compile in with UART_RX_FILTER_GLITCH_CNT_EN.
module tb_uart_rx_filter_multi;

  localparam int NT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       samp = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] ina = 4'hF;
  logic [1:0] inb = 2'h3;

  always #5 clk = ~clk;

  uart_rx_filter_multi_if #(.NCH(4)) ifa ();
  uart_rx_filter_multi_if #(.NCH(2)) ifb ();

  assign ifa.samp_clk = samp;
  assign ifa.in       = ina;
  assign ifb.samp_clk = samp;
  assign ifb.in       = inb;
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  assign ifa.glitch_clr = clr;
  assign ifb.glitch_clr = clr;
`endif

  uart_rx_filter_multi #(.NCH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  uart_rx_filter_multi #(
    .NCH(2), .CNT_W(3), .THRESH_HI(6), .THRESH_LO(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Lane model: ch0-3 default lanes, ch4-5 the CNT_W=3 lanes.
  int cmx[NT] = '{3, 3, 3, 3, 7, 7};
  int hi[NT]  = '{3, 3, 3, 3, 6, 6};
  int lo[NT]  = '{0, 0, 0, 0, 1, 1};
  bit sq[NT][$];
  int mc[NT];
  int mg[NT];
  bit mo[NT], mr[NT], mf[NT], mx[NT];
  bit chk_en = 1'b0;

  function automatic bit in_of(input int c);
    return (c < 4) ? ina[c] : inb[c-4];
  endfunction

  function automatic bit g_out(input int c);
    return (c < 4) ? ifa.out[c] : ifb.out[c-4];
  endfunction

  function automatic bit g_rise(input int c);
    return (c < 4) ? ifa.rise[c] : ifb.rise[c-4];
  endfunction

  function automatic bit g_fall(input int c);
    return (c < 4) ? ifa.fall[c] : ifb.fall[c-4];
  endfunction

`ifdef UART_RX_FILTER_GLITCH_CNT_EN
  function automatic int g_gc(input int c);
    return (c < 4) ? int'(ifa.glitch_cnt[c*8 +: 8])
                   : int'(ifb.glitch_cnt[(c-4)*8 +: 8]);
  endfunction
`endif

  always @(posedge clk) begin
    for (int c = 0; c < NT; c++) begin
      bit old, nv, ev;
      int pre;
      if (rst) begin
        sq[c].delete();
        sq[c].push_back(1'b1);
        sq[c].push_back(1'b1);
        mc[c] = cmx[c];
        mo[c] = 1'b1;
        mr[c] = 1'b0;
        mf[c] = 1'b0;
        mx[c] = 1'b0;
        mg[c] = 0;
      end else begin
        mr[c] = 1'b0;
        mf[c] = 1'b0;
        if (samp) begin
          old = sq[c].pop_front();
          sq[c].push_back(in_of(c));
          pre = mc[c];
          nv = (pre >= hi[c]) ? 1'b1 :
               (pre <= lo[c]) ? 1'b0 : mo[c];
          if (old) mc[c] = (pre < cmx[c]) ? pre + 1 : pre;
          else     mc[c] = (pre > 0) ? pre - 1 : pre;
          mr[c] = nv && !mo[c];
          mf[c] = !nv && mo[c];
          ev = 1'b0;
          if (nv != mo[c]) mx[c] = 1'b0;
          else if (mo[c] ? (pre < hi[c]) : (pre > lo[c])) mx[c] = 1'b1;
          else if (mx[c]) begin
            mx[c] = 1'b0;
            ev = 1'b1;
          end
          if (clr) mg[c] = 0;
          else if (ev && (mg[c] < 255)) mg[c]++;
          mo[c] = nv;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NT; c++) begin
        chk($sformatf("out[%0d]", c), int'(g_out(c)), int'(mo[c]));
        chk($sformatf("rise[%0d]", c), int'(g_rise(c)), int'(mr[c]));
        chk($sformatf("fall[%0d]", c), int'(g_fall(c)), int'(mf[c]));
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
        chk($sformatf("gcnt[%0d]", c), g_gc(c), mg[c]);
`endif
      end
    end
  end

  int  rcnt[NT];
  int  fcnt[NT];
  int  gt = 0;
  bit  alt_b = 1'b0;

  task automatic cyc();
    @(negedge clk);
    #1;
    for (int c = 0; c < NT; c++) begin
      if (g_rise(c)) rcnt[c]++;
      if (g_fall(c)) fcnt[c]++;
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < NT; c++) begin
      rcnt[c] = 0;
      fcnt[c] = 0;
    end
  endtask

  task automatic tick();
    samp = 1'b0;
    repeat (3) cyc();
    if (alt_b)
      inb = {(((gt + 1) / 3) % 2) == 0, ((gt / 3) % 2) == 0};
    samp = 1'b1;
    cyc();
    samp = 1'b0;
    gt++;
  endtask

  initial begin
    int lat[3];
    int st[3];
    int flat;
    int run[NT];
    int sum;

    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_out_a", int'(ifa.out), 15);
    chk("rst_out_b", int'(ifb.out), 3);
    chk("rst_strobes", int'({ifa.rise, ifa.fall, ifb.rise, ifb.fall}), 0);
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
    chk("rst_gcnt_a", int'(ifa.glitch_cnt), 0);
`endif
    rst = 1'b0;

    // Lanes 0-2 go low then step high at distinct times; lane 3 stays high.
    ina = 4'b1000;
    alt_b = 1'b1;
    repeat (10) tick();
    chk("p1_low", int'(ifa.out), 8);
    clr_cnt();
    st = '{0, 2, 4};
    lat = '{-1, -1, -1};
    for (int t = 0; t < 16; t++) begin
      for (int c = 0; c < 3; c++)
        if (t == st[c]) ina[c] = 1'b1;
      tick();
      for (int c = 0; c < 3; c++)
        if (lat[c] < 0 && g_out(c)) lat[c] = t - st[c] + 1;
    end
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rise_lat[%0d]", c), lat[c], 6);
      chk($sformatf("rise_n[%0d]", c), rcnt[c], 1);
      chk($sformatf("fall_n[%0d]", c), fcnt[c], 0);
    end
    chk("const_strobes", rcnt[3] + fcnt[3], 0);
    chk("alt_b_strobes", rcnt[4] + fcnt[4] + rcnt[5] + fcnt[5], 0);
    chk("alt_b_out", int'(ifb.out), 3);
    alt_b = 1'b0;
    inb = 2'h3;
    repeat (8) tick();

    // Single-tick dips on lanes 0 and 1.
    clr_cnt();
    ina = 4'b1100;
    tick();
    ina = 4'hF;
    repeat (6) tick();
    chk("dip_out", int'(ifa.out), 15);
    chk("dip_fall0", fcnt[0], 0);
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
    chk("dip_gcnt0", g_gc(0), 1);
    chk("dip_gcnt1", g_gc(1), 1);
    chk("dip_gcnt2", g_gc(2), 0);
`endif

    // Dip lane 1 again and clear on the very tick its count lands.
    ina = 4'b1101;
    tick();
    ina = 4'hF;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
`ifdef UART_RX_FILTER_GLITCH_CNT_EN
    chk("clr_gcnt0", g_gc(0), 0);
    chk("clr_gcnt1", g_gc(1), 0);
`endif

    // Strobe held low: inputs thrash, nothing may move.
    clr_cnt();
    samp = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ina = 4'($urandom);
      inb = 2'($urandom);
      cyc();
    end
    sum = 0;
    for (int c = 0; c < NT; c++) sum += rcnt[c] + fcnt[c];
    chk("frz_strobes", sum, 0);
    chk("frz_out_a", int'(ifa.out), 15);
    chk("frz_out_b", int'(ifb.out), 3);
    ina = 4'hF;
    inb = 2'h3;
    repeat (2) tick();

    // Reset part-way down a fall on lane 0.
    ina = 4'b1110;
    repeat (3) tick();
    chk("mid_fall_cnt", mc[0], 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mfr_out", int'(ifa.out), 15);
    chk("mfr_strobes", int'({ifa.rise, ifa.fall}), 0);
    flat = -1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (flat < 0 && !g_out(0)) flat = t + 1;
    end
    chk("fall_lat", flat, 6);

    // Random traffic with irregular strobe spacing.
    for (int c = 0; c < NT; c++) run[c] = $urandom_range(1, 8);
    for (int i = 0; i < 1500; i++) begin
      samp = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      if (samp) begin
        for (int c = 0; c < NT; c++) begin
          run[c]--;
          if (run[c] <= 0) begin
            run[c] = $urandom_range(1, 9);
            if (c < 4) ina[c] = ~ina[c];
            else inb[c-4] = ~inb[c-4];
          end
        end
      end
      cyc();
    end
    rst = 1'b0;
    clr = 1'b0;
    samp = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_filter_multi.md
Name: uart_rx_filter_multi

Overview:
- Multi-channel, parametrised successor to the single-bit UART RX deglitch filter.
- Each channel runs one async input through an N-stage synchroniser, then a saturating up/down counter with independent high/low hysteresis thresholds.
- Outputs per channel: a filtered level and one-clk rise/fall strobes.
- Sits between the pins and the UART RX/line-monitor logic. All activity is gated by the shared oversampling strobe samp_clk.

Parameters:
- NCH, 1: number of independent channels.
- SYNC_STAGES, 2: synchroniser depth; must be ≥2.
- CNT_W, 2: filter counter width; saturates at CMAX = 2^CNT_W-1.
- THRESH_HI, 3: out is set to 1 when cnt ≥ THRESH_HI.
- THRESH_LO, 0: out is set to 0 when cnt ≤ THRESH_LO. Requires THRESH_LO < THRESH_HI ≤ CMAX.
- RESET_VAL, 1: idle level loaded into the synchroniser and out on reset (UART idles high).
- GCNT_W, 8: glitch counter width (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- samp_clk  in  1  one-clk-wide sample enable
- in  in  NCH  async raw inputs
- out  out  NCH  filtered levels
- rise  out  NCH  one-clk pulse when out goes 0→1
- fall  out  NCH  one-clk pulse when out goes 1→0
- glitch_clr  in  1  clears all glitch counters (optional feature)
- glitch_cnt  out  NCH*GCNT_W  per-channel glitch counts; channel i at [i*GCNT_W +: GCNT_W] (optional feature)

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst. Only rst and the rise/fall clearing act on cycles without samp_clk.
- Reset values:
  - sync stages = RESET_VAL.
  - cnt = CMAX if RESET_VAL else 0.
  - out = RESET_VAL.
  - rise = fall = 0.
  - glitch_cnt = 0, excursion flags = 0.
  - rst wins over samp_clk. Reset mid-transition abandons the partial count.
- Per channel, on a clk edge with samp_clk=1:
  - Synchroniser shifts in[i] in. in_sync is the oldest stage, pre-edge value.
  - If in_sync=1 and cnt≠CMAX: cnt+1. If in_sync=0 and cnt≠0: cnt-1. Otherwise hold. Never wraps.
  - out uses the pre-edge cnt: cnt ≥ THRESH_HI → 1; cnt ≤ THRESH_LO → 0; otherwise hold.
- Edge strobes:
  - rise[i] = 1 for exactly the clk cycle following an edge where out[i] changed 0→1; fall[i] likewise for 1→0.
  - Both are cleared on the next clk edge regardless of samp_clk. They are never both 1.
- Latency with a settled counter at the opposite rail: out changes SYNC_STAGES + THRESH_HI + 1 samp_clk ticks after the input changes (6 with defaults). Falling latency is SYNC_STAGES + (CMAX-THRESH_LO) + 1.
- A toggling input whose run lengths never drive cnt across a threshold leaves out unchanged.
- samp_clk held low freezes all state except the strobe clearing.
- Channels are fully independent. A simultaneous event on all channels is legal.

Optional Feature:
- Macro: UART_RX_FILTER_GLITCH_CNT_EN.
- Defined:
  - A per-channel excursion flag is set when out=0 and cnt > THRESH_LO, or when out=1 and cnt < THRESH_HI.
  - The flag clears without counting when out toggles.
  - If cnt instead returns to its rail (≤THRESH_LO with out=0, ≥THRESH_HI with out=1), the flag clears and glitch_cnt[i] += 1.
  - glitch_cnt saturates at 2^GCNT_W-1.
  - glitch_clr zeroes all counters. If glitch_clr and a count event occur in the same edge, the result is 0.
- Undefined: glitch_clr and glitch_cnt ports and all related logic are absent.

Decomposition:
- Package uart_filter_pkg:
  - function cmax(CNT_W);
  - parameter-legality check function (THRESH_LO < THRESH_HI ≤ CMAX, SYNC_STAGES ≥ 2);
  - localparam for the reset rail.
- Sub-module uart_rx_filter_chan: one synchroniser, counter, out, strobes and optional glitch counter.
- Top level instantiates NCH copies in a generate loop and packs the vectors.

Test Plan:
- Defaults, NCH=1, in low for 10 ticks then high, samp_clk every 4th clk → out=1 exactly 6 ticks after the in rise; rise high for one clk; fall never set.
- Defaults, out=1 settled, in low for a single tick → out stays 1; with the optional feature, glitch_cnt=1 after cnt returns to 3.
- CNT_W=3, THRESH_HI=6, THRESH_LO=1, in alternating 3 ticks high / 3 low → out never changes, no strobes.
- samp_clk held 0 for 50 clk while in toggles → out, cnt and strobes unchanged.
- rst asserted for one clk when cnt=2 mid-fall → next cycle out=1 (RESET_VAL), cnt=3, strobes 0; counting restarts from the rail.
- NCH=4, channels given distinct step times, one channel held constant → each out switches at its own 6-tick latency; the constant channel never strobes; glitch_clr coincident with a count event leaves that counter at 0.
